upsample: RTL and testbench

Interpolating counterpart to the `subsample` decimator. Accepts one sample per input handshake and emits `UPSAMPLE_FACTOR` output beats per sample, either by sample-and-hold or by zero-insertion. It sits between a `subsample`d domain and any stage that needs the original rate restored. Valid/ready handshaking is on both sides, with a one-entry pending buffer so back-to-back samples stream without bubbles.

---
 rtl/upsample.sv | 63 ++++++
 tb/tb_upsample.sv | 114 +++++++++++
 2 files changed

// File: rtl/upsample.sv
// upsample: interpolator emitting UPSAMPLE_FACTOR beats per sample (hold or zero-insert),
// with a one-entry pending buffer so back-to-back samples stream without bubbles.
module upsample #(
  parameter int DATA_WIDTH      = 12,
  parameter int UPSAMPLE_FACTOR = 400,
  parameter int ZERO_STUFF      = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  upsample_ready_in,
  input  logic                  upsample_valid_in,
  input  logic [DATA_WIDTH-1:0] upsample_data_in,
  input  logic                  upsample_ready_out,
  output logic                  upsample_valid_out,
  output logic [DATA_WIDTH-1:0] upsample_data_out,
  output logic                  upsample_last_out
);
  localparam int COUNTER_WIDTH = UPSAMPLE_FACTOR > 1 ? $clog2(UPSAMPLE_FACTOR) : 1;
  localparam logic [COUNTER_WIDTH-1:0] LAST = COUNTER_WIDTH'(UPSAMPLE_FACTOR - 1);
  logic [DATA_WIDTH-1:0] hold, pend_data, ld_data;
  logic [COUNTER_WIDTH-1:0] count, count_inc;
  logic pend_v, ih, oh, fb, ld;
  assign upsample_ready_in = !pend_v;
  assign ih = upsample_valid_in && !pend_v;
  assign oh = upsample_valid_out && upsample_ready_out;
  assign fb = oh && count == LAST;
  assign count_inc = count + COUNTER_WIDTH'(1);
  // A pending sample always wins over a new input at the burst boundary; ih is 0 then anyway.
  assign ld = (!upsample_valid_out && ih) || (fb && (pend_v || ih));
  assign ld_data = (fb && pend_v) ? pend_data : upsample_data_in;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      upsample_valid_out <= 1'b0;
      upsample_data_out  <= '0;
      upsample_last_out  <= 1'b0;
      hold               <= '0;
      count              <= '0;
      pend_data          <= '0;
      pend_v             <= 1'b0;
    end else begin
      if (ld) begin
        upsample_valid_out <= 1'b1;
        hold               <= ld_data;
        upsample_data_out  <= ld_data;
        count              <= '0;
        upsample_last_out  <= UPSAMPLE_FACTOR == 1;
      end else if (fb) begin
        upsample_valid_out <= 1'b0;
        upsample_last_out  <= 1'b0;
      end else if (oh) begin
        count             <= count_inc;
        upsample_data_out <= ZERO_STUFF != 0 ? '0 : hold;
        upsample_last_out <= count_inc == LAST;
      end
      if (fb && pend_v) begin
        pend_v <= 1'b0;
      end else if (ih && upsample_valid_out && !fb) begin
        pend_v    <= 1'b1;
        pend_data <= upsample_data_in;
      end
    end
  end
endmodule

// File: tb/tb_upsample.sv
// tb_upsample: four configurations driven in parallel and scored against a beat-queue model.
module tb_upsample;
  localparam int N = 4;
  localparam int FAC [N] = '{4, 4, 3, 1};
  localparam int ZS  [N] = '{0, 1, 0, 0};
  logic clk = 0, rst = 1;
  logic valid_in = 0, ready_out = 0;
  logic [11:0] data_in = '0;
  logic [N-1:0] ri, vo, lo;
  logic [N-1:0][11:0] dout;
  int q [N][$];
  int vectors = 0, errors = 0;
  bit exp_ready [N];
  always #5 clk = ~clk;
  upsample #(.DATA_WIDTH(12), .UPSAMPLE_FACTOR(4), .ZERO_STUFF(0)) u0 (.clk(clk), .rst(rst),
    .upsample_ready_in(ri[0]), .upsample_valid_in(valid_in), .upsample_data_in(data_in),
    .upsample_ready_out(ready_out), .upsample_valid_out(vo[0]), .upsample_data_out(dout[0]),
    .upsample_last_out(lo[0]));
  upsample #(.DATA_WIDTH(12), .UPSAMPLE_FACTOR(4), .ZERO_STUFF(1)) u1 (.clk(clk), .rst(rst),
    .upsample_ready_in(ri[1]), .upsample_valid_in(valid_in), .upsample_data_in(data_in),
    .upsample_ready_out(ready_out), .upsample_valid_out(vo[1]), .upsample_data_out(dout[1]),
    .upsample_last_out(lo[1]));
  upsample #(.DATA_WIDTH(12), .UPSAMPLE_FACTOR(3), .ZERO_STUFF(0)) u2 (.clk(clk), .rst(rst),
    .upsample_ready_in(ri[2]), .upsample_valid_in(valid_in), .upsample_data_in(data_in),
    .upsample_ready_out(ready_out), .upsample_valid_out(vo[2]), .upsample_data_out(dout[2]),
    .upsample_last_out(lo[2]));
  upsample #(.DATA_WIDTH(12), .UPSAMPLE_FACTOR(1), .ZERO_STUFF(0)) u3 (.clk(clk), .rst(rst),
    .upsample_ready_in(ri[3]), .upsample_valid_in(valid_in), .upsample_data_in(data_in),
    .upsample_ready_out(ready_out), .upsample_valid_out(vo[3]), .upsample_data_out(dout[3]),
    .upsample_last_out(lo[3]));

  task automatic cmp(input string tag, input int i, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s[%0d] t=%0t observed=%0h expected=%0h", tag, i, $time, obs, exp);
    end
  endtask

  // Model: each instance is a queue of pending beats {last,data}; ready_in is high
  // whenever no more than one sample's worth of beats is still outstanding.
  task automatic check_all();
    for (int i = 0; i < N; i++) begin
      exp_ready[i] = q[i].size() <= FAC[i];
      cmp("ready_in", i, int'(ri[i]), int'(exp_ready[i]));
      cmp("valid_out", i, int'(vo[i]), int'(q[i].size() > 0));
      if (q[i].size() > 0) begin
        cmp("data_out", i, int'(dout[i]), q[i][0] & 12'hfff);
        cmp("last_out", i, int'(lo[i]), (q[i][0] >> 12) & 1);
      end
    end
  endtask

  task automatic step(input bit vin, input logic [11:0] din, input bit rout);
    bit pop [N];
    bit push [N];
    @(negedge clk);
    valid_in = vin;
    data_in = din;
    ready_out = rout;
    #1 check_all();
    for (int i = 0; i < N; i++) begin
      pop[i] = rout && q[i].size() > 0;
      push[i] = vin && exp_ready[i];
    end
    @(posedge clk);
    for (int i = 0; i < N; i++) begin
      if (pop[i]) void'(q[i].pop_front());
      if (push[i])
        for (int b = 0; b < FAC[i]; b++)
          q[i].push_back(((b == FAC[i] - 1) ? 32'h1000 : 0) | ((ZS[i] != 0 && b > 0) ? 0 : int'(din)));
    end
  endtask

  task automatic check_reset();
    for (int i = 0; i < N; i++) begin
      cmp("rst_valid", i, int'(vo[i]), 0);
      cmp("rst_data", i, int'(dout[i]), 0);
      cmp("rst_last", i, int'(lo[i]), 0);
      cmp("rst_ready", i, int'(ri[i]), 1);
    end
  endtask

  initial begin
    #1 check_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    step(1, 12'h123, 1);
    for (int k = 0; k < 6; k++) step(0, 12'h000, 1);
    step(1, 12'habc, 1);
    for (int k = 0; k < 6; k++) step(0, 12'h000, 1);
    for (int k = 1; k <= 12; k++) step(1, 12'(k), 1);
    for (int k = 0; k < 14; k++) step(0, 12'h000, 1);
    for (int k = 0; k < 400; k++)
      step(1'($urandom_range(0, 3) != 0), 12'($urandom), 1'($urandom_range(0, 2) != 0));
    for (int k = 0; k < 3; k++) step(1, 12'(k + 7), 1);
    for (int k = 0; k < 2; k++) step(1, 12'h3c3, 0);
    @(negedge clk);
    #3 rst = 1;
    #1 check_reset();
    for (int i = 0; i < N; i++) q[i].delete();
    valid_in = 0;
    @(negedge clk);
    rst = 0;
    step(1, 12'h055, 1);
    for (int k = 0; k < 6; k++) step(0, 12'h000, 1);
    for (int k = 1; k <= 5; k++) step(1, 12'(k), 1);
    for (int k = 0; k < 16; k++) step(0, 12'h000, 1);
    for (int i = 0; i < N; i++) cmp("drained", i, int'(vo[i]), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
